// File: rtl/id_ex_pipe_reg_pkg.sv
// Encodings and the control bundle shared between the decoder/control unit
// and the ID/EX pipeline register.
package id_ex_pipe_reg_pkg;

  localparam logic [1:0] REGDST_RD  = 2'd0;
  localparam logic [1:0] REGDST_RT  = 2'd1;
  localparam logic [1:0] REGDST_FD  = 2'd2;
  localparam logic [1:0] REGDST_R31 = 2'd3;

  localparam logic [2:0] WBSRC_ALU = 3'd0;
  localparam logic [2:0] WBSRC_MEM = 3'd1;
  localparam logic [2:0] WBSRC_LUI = 3'd2;
  localparam logic [2:0] WBSRC_PC4 = 3'd3;

  localparam logic [2:0] EXOP_ALU    = 3'd0;
  localparam logic [2:0] EXOP_SHIFT  = 3'd1;
  localparam logic [2:0] EXOP_MULDIV = 3'd2;
  localparam logic [2:0] EXOP_BRANCH = 3'd3;
  localparam logic [2:0] EXOP_MEM    = 3'd4;
  localparam logic [2:0] EXOP_FPU    = 3'd5;
  localparam logic [2:0] EXOP_CP0    = 3'd6;
  localparam logic [2:0] EXOP_NOP    = 3'd7;

  // Packed so a bubble is a single '0 assignment.
  typedef struct packed {
    logic       jr;
    logic       byte_op;
    logic       jump;
    logic       memwrite;
    logic       regwrite;
    logic       fp;
    logic       shift;
    logic       dw;
    logic [1:0] regdst;
    logic [2:0] wbsrc;
    logic [2:0] exop;
  } ctrl_t;

  function automatic logic is_load(input ctrl_t c);
    return c.regwrite && (c.wbsrc == WBSRC_MEM);
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Combinational load-use compare of the ID source registers against the
// load currently occupying EX.
module load_use_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic              ex_dw,
  input  logic              ex_fp,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_fp,
  output logic              hazard
);

  logic dest_live;
  logic hit;

  // A double-word destination covers the even/odd pair, so bit 0 is ignored.
  function automatic logic same_reg(input logic [REG_AW-1:0] a,
                                    input logic [REG_AW-1:0] b,
                                    input logic              pair);
    if (pair) return a[REG_AW-1:1] == b[REG_AW-1:1];
    return a == b;
  endfunction

  always_comb begin
    dest_live = ex_fp || (ex_dest != '0);
    hit       = same_reg(id_rs, ex_dest, ex_dw)
             || same_reg(id_rt, ex_dest, ex_dw)
             || (id_fp && same_reg(id_rd, ex_dest, ex_dw));
    hazard    = ex_valid && ex_load && dest_live && hit;
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures the decoded bundle and operands, inserts
// a bubble on load-use hazards, and honours flush and external stall.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_jr,
  input  logic              id_byte,
  input  logic              id_jump,
  input  logic              id_memwrite,
  input  logic              id_regwrite,
  input  logic              id_float,
  input  logic              id_shift,
  input  logic              id_dw,
  input  logic [1:0]        id_regdst,
  input  logic [2:0]        id_wbsrc,
  input  logic [2:0]        id_exop,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_shamt,
  input  logic [5:0]        id_fun,
  input  logic              flush,
  input  logic              stall_ext,
  output logic              ex_jr,
  output logic              ex_byte,
  output logic              ex_jump,
  output logic              ex_memwrite,
  output logic              ex_regwrite,
  output logic              ex_float,
  output logic              ex_shift,
  output logic              ex_dw,
  output logic [1:0]        ex_regdst,
  output logic [2:0]        ex_wbsrc,
  output logic [2:0]        ex_exop,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_shamt,
  output logic [5:0]        ex_fun,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_dest,
  output logic              stall_o
);

  typedef struct packed {
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] shamt;
    logic [REG_AW-1:0] dest;
    logic [5:0]        fun;
  } data_t;

  ctrl_t ctrl_d, ctrl_q, id_ctrl;
  data_t data_d, data_q, id_data;
  logic  valid_d, valid_q;
  logic  hazard;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .ex_valid (valid_q),
    .ex_load  (is_load(ctrl_q)),
    .ex_dw    (ctrl_q.dw),
    .ex_fp    (ctrl_q.fp),
    .ex_dest  (data_q.dest),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .id_rd    (id_rd),
    .id_fp    (id_float),
    .hazard   (hazard)
  );

  always_comb begin
    id_ctrl = '{jr: id_jr, byte_op: id_byte, jump: id_jump, memwrite: id_memwrite,
                regwrite: id_regwrite, fp: id_float, shift: id_shift, dw: id_dw,
                regdst: id_regdst, wbsrc: id_wbsrc, exop: id_exop};

    id_data         = '0;
    id_data.pc4     = id_pc4;
    id_data.rs_data = id_rs_data;
    id_data.rt_data = id_rt_data;
    id_data.imm     = id_imm;
    id_data.rs      = id_rs;
    id_data.rt      = id_rt;
    id_data.rd      = id_rd;
    id_data.shamt   = id_shamt;
    id_data.fun     = id_fun;
    unique case (id_regdst)
      REGDST_RD:  id_data.dest = id_rd;
      REGDST_RT:  id_data.dest = id_rt;
      REGDST_FD:  id_data.dest = id_shamt;
      default:    id_data.dest = REG_AW'(31);
    endcase
  end

  // Bubbles clear only the control bundle and valid; data fields keep their values.
  always_comb begin
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else if (!stall_ext) begin
      if (hazard) begin
        ctrl_d  = '0;
        valid_d = 1'b0;
      end else begin
        ctrl_d  = id_ctrl;
        data_d  = id_data;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    stall_o     = rst_n && hazard && !flush && !stall_ext;
    ex_jr       = ctrl_q.jr;
    ex_byte     = ctrl_q.byte_op;
    ex_jump     = ctrl_q.jump;
    ex_memwrite = ctrl_q.memwrite;
    ex_regwrite = ctrl_q.regwrite;
    ex_float    = ctrl_q.fp;
    ex_shift    = ctrl_q.shift;
    ex_dw       = ctrl_q.dw;
    ex_regdst   = ctrl_q.regdst;
    ex_wbsrc    = ctrl_q.wbsrc;
    ex_exop     = ctrl_q.exop;
    ex_pc4      = data_q.pc4;
    ex_rs_data  = data_q.rs_data;
    ex_rt_data  = data_q.rt_data;
    ex_imm      = data_q.imm;
    ex_rs       = data_q.rs;
    ex_rt       = data_q.rt;
    ex_rd       = data_q.rd;
    ex_shamt    = data_q.shamt;
    ex_fun      = data_q.fun;
    ex_dest     = data_q.dest;
    ex_valid    = valid_q;
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: reset, pass-through, load-use bubbles,
// FP pair compare, $zero, flush/stall priority and reset during a stall.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_jr, id_byte, id_jump, id_memwrite, id_regwrite, id_float, id_shift, id_dw;
  logic [1:0]  id_regdst;
  logic [2:0]  id_wbsrc, id_exop;
  logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [5:0]  id_fun;
  logic        flush, stall_ext;
  logic        ex_jr, ex_byte, ex_jump, ex_memwrite, ex_regwrite, ex_float, ex_shift, ex_dw;
  logic [1:0]  ex_regdst;
  logic [2:0]  ex_wbsrc, ex_exop;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [5:0]  ex_fun;
  logic        ex_valid;
  logic [4:0]  ex_dest;
  logic        stall_o;

  int checks = 0;
  int errors = 0;

  id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_jr(id_jr), .id_byte(id_byte), .id_jump(id_jump), .id_memwrite(id_memwrite),
    .id_regwrite(id_regwrite), .id_float(id_float), .id_shift(id_shift), .id_dw(id_dw),
    .id_regdst(id_regdst), .id_wbsrc(id_wbsrc), .id_exop(id_exop),
    .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt), .id_fun(id_fun),
    .flush(flush), .stall_ext(stall_ext),
    .ex_jr(ex_jr), .ex_byte(ex_byte), .ex_jump(ex_jump), .ex_memwrite(ex_memwrite),
    .ex_regwrite(ex_regwrite), .ex_float(ex_float), .ex_shift(ex_shift), .ex_dw(ex_dw),
    .ex_regdst(ex_regdst), .ex_wbsrc(ex_wbsrc), .ex_exop(ex_exop),
    .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_fun(ex_fun),
    .ex_valid(ex_valid), .ex_dest(ex_dest), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {id_jr, id_byte, id_jump, id_memwrite, id_regwrite, id_float, id_shift, id_dw} = '0;
    id_regdst = '0; id_wbsrc = '0; id_exop = '0;
    id_pc4 = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_shamt = '0; id_fun = '0;
    flush = 1'b0; stall_ext = 1'b0;
  endtask

  // Drives a load (wbsrc=memory, dest via rt) into ID and clocks it into EX.
  task automatic load_into_ex(input logic [4:0] dst, input logic fp, input logic dw);
    idle();
    id_regwrite = 1'b1; id_wbsrc = 3'd1; id_regdst = 2'd1;
    id_rt = dst; id_rs = 5'd29; id_float = fp; id_dw = dw;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {id_jr, id_byte, id_jump, id_memwrite, id_regwrite, id_float, id_shift, id_dw} = 8'($urandom);
    id_regdst = 2'($urandom); id_wbsrc = 3'($urandom); id_exop = 3'($urandom);
    id_imm = $urandom; id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
    flush = 1'b0; stall_ext = 1'b0;
    tick();
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ex_valid); end
    checks++; if (ex_regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %0b want 0", ex_regwrite); end
    checks++; if (ex_dest !== 5'd0) begin errors++; $display("FAIL reset_dest got %0d want 0", ex_dest); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall_o); end
    checks++; if (ex_imm !== 32'd0) begin errors++; $display("FAIL reset_imm got %h want 0", ex_imm); end
    rst_n = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_pass_through();
    idle();
    id_regwrite = 1'b1; id_regdst = 2'd1; id_rt = 5'd9; id_rs = 5'd4; id_rd = 5'd21;
    id_imm = 32'h1234; id_pc4 = 32'h0040_0008; id_exop = 3'd0;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL pass_stall_pre got %0b want 0", stall_o); end
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL pass_valid got %0b want 1", ex_valid); end
    checks++; if (ex_dest !== 5'd9) begin errors++; $display("FAIL pass_dest got %0d want 9", ex_dest); end
    checks++; if (ex_imm !== 32'h1234) begin errors++; $display("FAIL pass_imm got %h want 1234", ex_imm); end
    checks++; if (ex_pc4 !== 32'h0040_0008) begin errors++; $display("FAIL pass_pc4 got %h want 00400008", ex_pc4); end
    checks++; if (ex_regwrite !== 1'b1) begin errors++; $display("FAIL pass_regwrite got %0b want 1", ex_regwrite); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL pass_stall_post got %0b want 0", stall_o); end
  endtask

  task automatic test_load_use();
    load_into_ex(5'd8, 1'b0, 1'b0);
    idle();
    id_regwrite = 1'b1; id_regdst = 2'd0; id_rs = 5'd8; id_rt = 5'd2; id_rd = 5'd10; id_imm = 32'h55;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b want 1", stall_o); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble_valid got %0b want 0", ex_valid); end
    checks++; if (ex_regwrite !== 1'b0 || ex_wbsrc !== 3'd0 || ex_regdst !== 2'd0)
      begin errors++; $display("FAIL lu_bubble_ctrl got rw=%0b wb=%0d rd=%0d want 0 0 0", ex_regwrite, ex_wbsrc, ex_regdst); end
    checks++; if (ex_dest !== 5'd8 || ex_rs !== 5'd29)
      begin errors++; $display("FAIL lu_bubble_data got dest=%0d rs=%0d want 8 29", ex_dest, ex_rs); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_stall_clear got %0b want 0", stall_o); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_dest !== 5'd10 || ex_rs !== 5'd8 || ex_imm !== 32'h55)
      begin errors++; $display("FAIL lu_capture got v=%0b dest=%0d rs=%0d imm=%h want 1 10 8 55", ex_valid, ex_dest, ex_rs, ex_imm); end
  endtask

  task automatic test_dw_pair();
    load_into_ex(5'd4, 1'b1, 1'b1);
    idle();
    id_float = 1'b1; id_dw = 1'b1; id_regwrite = 1'b1; id_rd = 5'd5; id_rt = 5'd2; id_rs = 5'd0;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL dw_f5 got %0b want 1", stall_o); end
    id_rd = 5'd6;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL dw_f6 got %0b want 0", stall_o); end
    id_rd = 5'd5; id_float = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL dw_rd_not_src got %0b want 0", stall_o); end
    idle();
    tick();
    load_into_ex(5'd4, 1'b1, 1'b0);
    idle();
    id_float = 1'b1; id_rd = 5'd5;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL single_f5 got %0b want 0", stall_o); end
    idle();
    tick();
  endtask

  task automatic test_zero();
    load_into_ex(5'd0, 1'b0, 1'b0);
    checks++; if (ex_valid !== 1'b1 || ex_dest !== 5'd0)
      begin errors++; $display("FAIL zero_load got v=%0b dest=%0d want 1 0", ex_valid, ex_dest); end
    idle();
    id_regwrite = 1'b1; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL zero_int got %0b want 0", stall_o); end
    load_into_ex(5'd0, 1'b1, 1'b0);
    idle();
    id_float = 1'b1; id_rs = 5'd0;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL zero_fp got %0b want 1", stall_o); end
    idle();
    tick();
  endtask

  task automatic test_priority();
    load_into_ex(5'd8, 1'b0, 1'b0);
    idle();
    id_regwrite = 1'b1; id_rs = 5'd8; id_rd = 5'd12; flush = 1'b1;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL prio_flush_stall got %0b want 0", stall_o); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_dest !== 5'd8)
      begin errors++; $display("FAIL prio_flush_bubble got v=%0b rw=%0b dest=%0d want 0 0 8", ex_valid, ex_regwrite, ex_dest); end
    load_into_ex(5'd8, 1'b0, 1'b0);
    idle();
    id_rs = 5'd8; stall_ext = 1'b1;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL prio_ext_gate got %0b want 0", stall_o); end
    idle();
    tick();
  endtask

  task automatic test_stall_ext();
    idle();
    id_regwrite = 1'b1; id_wbsrc = 3'd3; id_regdst = 2'd3; id_jump = 1'b1; id_imm = 32'hA5A5;
    tick();
    checks++; if (ex_dest !== 5'd31 || ex_jump !== 1'b1)
      begin errors++; $display("FAIL hold_setup got dest=%0d jump=%0b want 31 1", ex_dest, ex_jump); end
    idle();
    stall_ext = 1'b1;
    id_regwrite = 1'b1; id_shift = 1'b1; id_regdst = 2'd2; id_shamt = 5'd17; id_imm = 32'hBEEF; id_fun = 6'h02;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ex_imm !== 32'hA5A5 || ex_dest !== 5'd31 || ex_valid !== 1'b1 || ex_jump !== 1'b1 || ex_shift !== 1'b0)
        begin errors++; $display("FAIL hold_cycle%0d got imm=%h dest=%0d v=%0b j=%0b sh=%0b want a5a5 31 1 1 0",
                                 i, ex_imm, ex_dest, ex_valid, ex_jump, ex_shift); end
    end
    stall_ext = 1'b0;
    tick();
    checks++; if (ex_imm !== 32'hBEEF || ex_dest !== 5'd17 || ex_shift !== 1'b1 || ex_jump !== 1'b0 || ex_fun !== 6'h02)
      begin errors++; $display("FAIL hold_release got imm=%h dest=%0d sh=%0b j=%0b fun=%h want beef 17 1 0 02",
                               ex_imm, ex_dest, ex_shift, ex_jump, ex_fun); end
  endtask

  task automatic test_reset_mid_stall();
    load_into_ex(5'd8, 1'b0, 1'b0);
    idle();
    id_rt = 5'd8;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %0b want 1", stall_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %0b want 0", stall_o); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_dest !== 5'd0)
      begin errors++; $display("FAIL rst_mid_empty got v=%0b dest=%0d want 0 0", ex_valid, ex_dest); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_dw_pair();
    test_zero();
    test_priority();
    test_stall_ext();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
